// File: rtl/koa_pkg.sv
// ---------------------------------------------------------------------------
// koa_pkg
//   Shared constants and types for the sequential Karatsuba multiplier
//   (koa_mult_seq) and its time-multiplexed 64x64 multiplier (koa_mul64_pipe).
//
//   KOA_W / KOA_HW    full operand width and half width
//   KOA_MUL_LAT_MAX   largest supported multiplier pipeline depth
//   koa_seq_state_e   controller states
//   koa_pp_idx_t      tag naming which partial product (p0/p1/p2) a
//                     multiplier result belongs to
// ---------------------------------------------------------------------------
package koa_pkg;

  localparam int KOA_W           = 128;
  localparam int KOA_HW          = 64;
  localparam int KOA_MUL_LAT_MAX = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE0 = 3'd1,
    ST_ISSUE1 = 3'd2,
    ST_ISSUE2 = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DONE   = 3'd5
  } koa_seq_state_e;

  typedef logic [1:0] koa_pp_idx_t;

  localparam koa_pp_idx_t PP_P0 = 2'd0;  // a0 * b0
  localparam koa_pp_idx_t PP_P1 = 2'd1;  // a1 * b1
  localparam koa_pp_idx_t PP_P2 = 2'd2;  // (a0^a1) * (b0^b1)

  // Low 128 bits of the combined product: the middle term lands 64 bits up,
  // so only its low half reaches the lower result word.
  function automatic logic [KOA_W-1:0] koa_lo_combine(
    input logic [KOA_W-1:0]  p0,
    input logic [KOA_HW-1:0] mid_lo
  );
    return p0 ^ {mid_lo, {KOA_HW{1'b0}}};
  endfunction

endpackage

// File: rtl/koa_mul64_pipe.sv
// ---------------------------------------------------------------------------
// koa_mul64_pipe
//   Shared 64x64 unsigned multiplier with MUL_LAT register stages. A valid
//   bit and a partial-product tag travel alongside each product so the
//   controller can steer results without tracking pipeline timing itself.
//   MUL_LAT = 0 makes the multiplier purely combinational.
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid, in_idx    issue strobe and tag for the operand pair
//     op_a, op_b          64-bit operands
//     out_valid, out_idx  strobe and tag delayed by MUL_LAT cycles
//     prod                128-bit product, aligned with out_valid
// ---------------------------------------------------------------------------
module koa_mul64_pipe import koa_pkg::*; #(
  parameter int MUL_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  koa_pp_idx_t        in_idx,
  input  logic [KOA_HW-1:0]  op_a,
  input  logic [KOA_HW-1:0]  op_b,
  output logic               out_valid,
  output koa_pp_idx_t        out_idx,
  output logic [KOA_W-1:0]   prod
);

  logic [KOA_W-1:0] prod_c;

  assign prod_c = KOA_W'(op_a) * KOA_W'(op_b);

  if (MUL_LAT < 0 || MUL_LAT > KOA_MUL_LAT_MAX) begin : g_lat_check
    $error("koa_mul64_pipe: MUL_LAT=%0d outside 0..%0d", MUL_LAT, KOA_MUL_LAT_MAX);
  end

  if (MUL_LAT == 0) begin : g_comb
    assign out_valid = in_valid;
    assign out_idx   = in_idx;
    assign prod      = prod_c;
  end else begin : g_pipe
    logic [KOA_W-1:0] prod_q  [MUL_LAT];
    logic             valid_q [MUL_LAT];
    koa_pp_idx_t      idx_q   [MUL_LAT];

    // NOTE: sequential state uses non-blocking (<=) so every stage samples
    // the previous stage's old value at the same edge; blocking here would
    // collapse the pipeline into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: the stage arrays are reset element by element; a stale
        // valid bit surviving reset would inject a phantom product.
        for (int i = 0; i < MUL_LAT; i++) begin
          prod_q[i]  <= '0;
          valid_q[i] <= 1'b0;
          idx_q[i]   <= PP_P0;
        end
      end else begin
        prod_q[0]  <= prod_c;
        valid_q[0] <= in_valid;
        idx_q[0]   <= in_idx;
        for (int i = 1; i < MUL_LAT; i++) begin
          prod_q[i]  <= prod_q[i-1];
          valid_q[i] <= valid_q[i-1];
          idx_q[i]   <= idx_q[i-1];
        end
      end
    end

    assign out_valid = valid_q[MUL_LAT-1];
    assign out_idx   = idx_q[MUL_LAT-1];
    assign prod      = prod_q[MUL_LAT-1];
  end

endmodule

// File: rtl/koa_mult_seq.sv
// ---------------------------------------------------------------------------
// koa_mult_seq
//   Area-reduced 128-bit Karatsuba multiplier. One shared 64x64 multiplier
//   (koa_mul64_pipe) is issued three times per transaction:
//     p0 = a0*b0, p1 = a1*b1, p2 = (a0^a1)*(b0^b1),  mid = p2^p0^p1
//     mult_d    = p0 ^ {mid[63:0], 64'b0}
//     mult_d_hi = p1 ^ {64'b0, mid[127:64]}   (KOA_SEQ_FULL_PRODUCT_EN only)
//   Result appears 3+MUL_LAT cycles after the accept edge and is held in
//   DONE until out_ready. DONE can accept the next operands in the same
//   cycle its result is taken.
//
//   Build option: define KOA_SEQ_FULL_PRODUCT_EN to add the mult_d_hi port
//   carrying the upper 128 bits of the combined product.
//
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     in_valid / in_ready  operand handshake (mult_a, mult_b sampled on accept)
//     out_valid / out_ready result handshake (mult_d, mult_d_hi)
//     busy                 a transaction is in flight (state != IDLE)
// ---------------------------------------------------------------------------
module koa_mult_seq import koa_pkg::*; #(
  parameter int MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [KOA_W-1:0]  mult_a,
  input  logic [KOA_W-1:0]  mult_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [KOA_W-1:0]  mult_d,
`ifdef KOA_SEQ_FULL_PRODUCT_EN
  output logic [KOA_W-1:0]  mult_d_hi,
`endif
  output logic              busy
);

  // WAIT lasts MUL_LAT cycles: the counter is loaded with MUL_LAT-1 and the
  // state exits when it reads zero, which is the cycle p2 leaves the pipe.
  localparam logic [1:0] WAIT_INIT = (MUL_LAT > 1) ? 2'(MUL_LAT - 1) : 2'd0;

  koa_seq_state_e    state_q, state_d;
  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic              accept;

  logic [KOA_W-1:0]  a_q, b_q;
  logic [KOA_HW-1:0] a0, a1, b0, b1;

  logic              issue_valid;
  koa_pp_idx_t       issue_idx;
  logic [KOA_HW-1:0] issue_a, issue_b;

  logic              pp_valid;
  koa_pp_idx_t       pp_idx;
  logic [KOA_W-1:0]  pp;

  logic [KOA_W-1:0]  acc_p0_q;
  logic [KOA_HW-1:0] mid_lo;
  logic [KOA_W-1:0]  mult_d_q;

`ifdef KOA_SEQ_FULL_PRODUCT_EN
  logic [KOA_W-1:0]  acc_p1_q;
  logic [KOA_W-1:0]  mid;
  logic [KOA_W-1:0]  mult_d_hi_q;
`else
  // Only the low half of mid reaches mult_d, so only the low half of p1 is kept.
  logic [KOA_HW-1:0] acc_p1_q;
`endif

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  assign in_ready  = rst_n && ((state_q == ST_IDLE) ||
                               ((state_q == ST_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block is assigned a default first, so no
    // path through the case statement can leave a latch behind.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ISSUE0;
      ST_ISSUE0: state_d = ST_ISSUE1;
      ST_ISSUE1: state_d = ST_ISSUE2;
      ST_ISSUE2: begin
        if (MUL_LAT == 0) begin
          state_d = ST_DONE;
        end else begin
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_INIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 2'd0) state_d = ST_DONE;
        else                    wait_cnt_d = wait_cnt_q - 2'd1;
      end
      ST_DONE: begin
        if (out_ready) state_d = accept ? ST_ISSUE0 : ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Operand capture and multiplier issue
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= mult_a;
      b_q <= mult_b;
    end
  end

  assign a0 = a_q[KOA_HW-1:0];
  assign a1 = a_q[KOA_W-1:KOA_HW];
  assign b0 = b_q[KOA_HW-1:0];
  assign b1 = b_q[KOA_W-1:KOA_HW];

  always_comb begin
    issue_valid = 1'b0;
    issue_idx   = PP_P0;
    issue_a     = '0;
    issue_b     = '0;
    unique case (state_q)
      ST_ISSUE0: begin
        issue_valid = 1'b1;
        issue_idx   = PP_P0;
        issue_a     = a0;
        issue_b     = b0;
      end
      ST_ISSUE1: begin
        issue_valid = 1'b1;
        issue_idx   = PP_P1;
        issue_a     = a1;
        issue_b     = b1;
      end
      ST_ISSUE2: begin
        issue_valid = 1'b1;
        issue_idx   = PP_P2;
        issue_a     = a0 ^ a1;
        issue_b     = b0 ^ b1;
      end
      default: ;
    endcase
  end

  koa_mul64_pipe #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue_valid),
    .in_idx    (issue_idx),
    .op_a      (issue_a),
    .op_b      (issue_b),
    .out_valid (pp_valid),
    .out_idx   (pp_idx),
    .prod      (pp)
  );

  // -------------------------------------------------------------------------
  // Accumulation and combination. p0/p1 are parked by tag; p2 is consumed
  // live from the multiplier output in the cycle it emerges.
  // -------------------------------------------------------------------------
`ifdef KOA_SEQ_FULL_PRODUCT_EN
  assign mid    = pp ^ acc_p0_q ^ acc_p1_q;
  assign mid_lo = mid[KOA_HW-1:0];
`else
  assign mid_lo = pp[KOA_HW-1:0] ^ acc_p0_q[KOA_HW-1:0] ^ acc_p1_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p0_q    <= '0;
      acc_p1_q    <= '0;
      mult_d_q    <= '0;
`ifdef KOA_SEQ_FULL_PRODUCT_EN
      mult_d_hi_q <= '0;
`endif
    end else if (pp_valid) begin
      unique case (pp_idx)
        PP_P0: acc_p0_q <= pp;
`ifdef KOA_SEQ_FULL_PRODUCT_EN
        PP_P1: acc_p1_q <= pp;
`else
        PP_P1: acc_p1_q <= pp[KOA_HW-1:0];
`endif
        PP_P2: begin
          mult_d_q    <= koa_lo_combine(acc_p0_q, mid_lo);
`ifdef KOA_SEQ_FULL_PRODUCT_EN
          mult_d_hi_q <= acc_p1_q ^ {{KOA_HW{1'b0}}, mid[KOA_W-1:KOA_HW]};
`endif
        end
        default: ;
      endcase
    end
  end

  assign mult_d = mult_d_q;
`ifdef KOA_SEQ_FULL_PRODUCT_EN
  assign mult_d_hi = mult_d_hi_q;
`endif

endmodule

// File: tb/tb_koa_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_koa_mult_seq
//   Four koa_mult_seq instances, one per MUL_LAT value 0..3 (lane index ==
//   MUL_LAT). Directed tests run on lane 1 (the default latency); the random
//   streaming test runs on all lanes at once. Expected results are pushed to
//   a shared scoreboard on accept and checked by per-lane monitors whenever a
//   result is presented. Define KOA_SEQ_FULL_PRODUCT_EN to also check
//   mult_d_hi.
// ---------------------------------------------------------------------------
module tb_koa_mult_seq;
  import koa_pkg::*;

  localparam int NL = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid  [NL];
  logic             in_ready  [NL];
  logic             out_valid [NL];
  logic             out_ready [NL];
  logic             busy      [NL];
  logic [KOA_W-1:0] mult_a    [NL];
  logic [KOA_W-1:0] mult_b    [NL];
  logic [KOA_W-1:0] mult_d    [NL];
`ifdef KOA_SEQ_FULL_PRODUCT_EN
  logic [KOA_W-1:0] mult_d_hi [NL];
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    koa_mult_seq #(.MUL_LAT(g)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .mult_a    (mult_a[g]),
      .mult_b    (mult_b[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .mult_d    (mult_d[g]),
`ifdef KOA_SEQ_FULL_PRODUCT_EN
      .mult_d_hi (mult_d_hi[g]),
`endif
      .busy      (busy[g])
    );
  end

  typedef struct {
    int               ln;
    int               acc;
    logic [KOA_W-1:0] d;
    logic [KOA_W-1:0] hi;
  } exp_t;

  exp_t sb[$];
  bit   seen_head [NL];

  task automatic check(input string name, input int ln,
                       input logic [KOA_W-1:0] act, input logic [KOA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d: got %h expected %h", name, ln, act, exp);
    end
  endtask

  // Reference: {p1,p0} with the middle term XORed in 64 bits up, as one
  // 256-bit value.
  function automatic logic [255:0] ref_full(input logic [KOA_W-1:0] a,
                                            input logic [KOA_W-1:0] b);
    logic [255:0] p0, p1, p2, mid;
    p0  = 256'(a[63:0]) * 256'(b[63:0]);
    p1  = 256'(a[127:64]) * 256'(b[127:64]);
    p2  = 256'(a[63:0] ^ a[127:64]) * 256'(b[63:0] ^ b[127:64]);
    mid = p0 ^ p1 ^ p2;
    return ((p1 << 128) | p0) ^ (mid << 64);
  endfunction

  function automatic logic [KOA_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called just after a rising edge. Returns just after the accept edge with
  // in_valid dropped and the operand inputs scrambled.
  task automatic send(input int ln, input logic [KOA_W-1:0] a, input logic [KOA_W-1:0] b,
                      input logic [KOA_W-1:0] d_exp, input logic [KOA_W-1:0] hi_exp,
                      output int acc);
    int   waited;
    exp_t e;
    waited = 0;
    acc = -1;
    in_valid[ln] = 1'b1;
    mult_a[ln]   = a;
    mult_b[ln]   = b;
    @(negedge clk);
    while (!in_ready[ln]) begin
      waited++;
      if (waited > 100) begin
        check("accept_timeout", ln, KOA_W'(waited), KOA_W'(0));
        in_valid[ln] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    acc   = cyc + 1;
    e.ln  = ln;
    e.acc = acc;
    e.d   = d_exp;
    e.hi  = hi_exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid[ln] = 1'b0;
    mult_a[ln]   = rnd128();
    mult_b[ln]   = rnd128();
  endtask

  task automatic send_model(input int ln, input logic [KOA_W-1:0] a, input logic [KOA_W-1:0] b);
    logic [255:0] full;
    int           acc;
    full = ref_full(a, b);
    send(ln, a, b, full[127:0], full[255:128], acc);
  endtask

  // Returns at the falling edge where out_valid is first seen.
  task automatic wait_out(input int ln, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid[ln]) begin
      n++;
      if (n > budget) begin
        check("out_valid_timeout", ln, KOA_W'(n), KOA_W'(0));
        return;
      end
      @(negedge clk);
    end
  endtask

  // Waits until every expected result has been consumed, then realigns to
  // just after a rising edge.
  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n <= budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 0, KOA_W'(sb.size()), KOA_W'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int ln);
    logic [KOA_W-1:0] a, b;
    out_ready[ln] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = rnd128();
      b = rnd128();
      if (i == 2) a = '1;
      if (i == 5) b = {b[63:0], b[63:0]};
      send_model(ln, a, b);
    end
  endtask

  // Per-lane monitor: latency on first presentation, data on handshake.
  for (genvar g = 0; g < NL; g++) begin : g_mon
    always @(negedge clk) begin : mon
      int idx;
      if (!rst_n) begin
        seen_head[g] = 1'b0;
      end else if (out_valid[g]) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (sb[i].ln == g) begin
            idx = i;
            break;
          end
        end
        if (!seen_head[g]) begin
          seen_head[g] = 1'b1;
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result lane%0d: got %h expected no result", g, mult_d[g]);
          end else begin
            check("latency", g, KOA_W'(cyc - sb[idx].acc), KOA_W'(3 + g));
          end
        end
        if (out_ready[g]) begin
          if (idx >= 0) begin
            check("mult_d", g, mult_d[g], sb[idx].d);
`ifdef KOA_SEQ_FULL_PRODUCT_EN
            check("mult_d_hi", g, mult_d_hi[g], sb[idx].hi);
`endif
            sb.delete(idx);
          end
          seen_head[g] = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KOA_W-1:0] a, b;
    logic [255:0]     full;
    int               acc, raise;

    for (int i = 0; i < NL; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
      mult_a[i]    = '0;
      mult_b[i]    = '0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NL; i++) begin
      check("rst_in_ready",  i, KOA_W'(in_ready[i]),  KOA_W'(0));
      check("rst_out_valid", i, KOA_W'(out_valid[i]), KOA_W'(0));
      check("rst_mult_d",    i, mult_d[i],            KOA_W'(0));
      check("rst_busy",      i, KOA_W'(busy[i]),      KOA_W'(0));
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < NL; i++) check("idle_in_ready", i, KOA_W'(in_ready[i]), KOA_W'(1));
    @(posedge clk);
    #1;

    // Basic result and all-ones operands
    send(1, 128'h1_0000000000000002, 128'h3_0000000000000004,
         128'h1E_0000000000000008, 128'h3, acc);
    wait_drain(40);
    send(1, '1, '1, 128'hFFFFFFFFFFFFFFFE_0000000000000001,
         128'hFFFFFFFFFFFFFFFE_0000000000000001, acc);
    wait_drain(40);

    // Backpressure: result held, in_valid pulses ignored
    out_ready[1] = 1'b0;
    a    = rnd128();
    b    = rnd128();
    full = ref_full(a, b);
    send(1, a, b, full[127:0], full[255:128], acc);
    wait_out(1, 20);
    for (int k = 0; k < 10; k++) begin
      check("bp_out_valid", 1, KOA_W'(out_valid[1]), KOA_W'(1));
      check("bp_mult_d",    1, mult_d[1],            full[127:0]);
      check("bp_in_ready",  1, KOA_W'(in_ready[1]),  KOA_W'(0));
      check("bp_busy",      1, KOA_W'(busy[1]),      KOA_W'(1));
      @(posedge clk);
      #1;
      in_valid[1] = (k >= 2 && k <= 6);
      mult_a[1]   = rnd128();
      mult_b[1]   = rnd128();
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b1;
    raise = cyc;
    send_model(1, rnd128(), rnd128());
    check("bp_same_cycle_accept", 1, KOA_W'(sb[sb.size()-1].acc), KOA_W'(raise + 1));
    wait_drain(40);

    // Reset during ISSUE1
    send_model(1, rnd128(), rnd128());
    @(posedge clk);
    #1;
    check("issue1_busy", 1, KOA_W'(busy[1]), KOA_W'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 1, KOA_W'(out_valid[1]), KOA_W'(0));
    check("midrst_mult_d",    1, mult_d[1],            KOA_W'(0));
    check("midrst_busy",      1, KOA_W'(busy[1]),      KOA_W'(0));
    check("midrst_in_ready",  1, KOA_W'(in_ready[1]),  KOA_W'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(1, 128'd2, 128'd3, 128'd6, 128'd0, acc);
    wait_out(1, 20);
    check("post_rst_mult_d", 1, mult_d[1], KOA_W'(6));
    wait_drain(40);

    // Operand change during ISSUE0 must not affect the result
    a = rnd128();
    b = rnd128();
    send_model(1, a, b);
    mult_a[1] = ~a;
    mult_b[1] = ~b;
    wait_drain(40);

    // Random streaming on every latency
    fork
      stream(0);
      stream(1);
      stream(2);
      stream(3);
    join
    for (int i = 0; i < NL; i++) in_valid[i] = 1'b0;
    wait_drain(300);

    check("scoreboard_empty", 0, KOA_W'(sb.size()), KOA_W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
